// File: rtl/dpcm_packer.sv
// dpcm_packer: variable-length packer for DPCM residuals.
//
// Each accepted residual is encoded as a 6-bit length header L followed by
// the L significant bits of the residual (MSB first), where L is the residual
// width without leading zeros (0..32). Codes are packed contiguously into a
// left-aligned bit buffer and emitted as 32-bit words, first-encoded bit at
// bit 31. A Flush pulse drains the final partial word, zero-padded, with Last.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ValidIn    in   residual on DataIn valid
//   DataIn     in   residual magnitude
//   ReadyIn    out  packer can accept a residual this cycle
//   Flush      in   single-cycle pulse: emit pending partial word
//   ValidOut   out  DataOut valid (registered)
//   DataOut    out  packed word (registered)
//   Last       out  DataOut is the flushed final word (registered)
//   ReadyOut   in   downstream accepts DataOut
//   Busy       out  buffered bits present or flush pending
//   SymCount   out  accepted residual count (only with DPCM_PACKER_STATS_EN)
//   WordCount  out  output word count (only with DPCM_PACKER_STATS_EN)
//
// Optional feature macro: DPCM_PACKER_STATS_EN adds SymCount/WordCount.

module dpcm_packer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned BUF_W  = 72
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ValidIn,
   input  logic [DATA_W-1:0] DataIn,
   output logic              ReadyIn,
   input  logic              Flush,
   output logic              ValidOut,
   output logic [DATA_W-1:0] DataOut,
   output logic              Last,
   input  logic              ReadyOut,
`ifdef DPCM_PACKER_STATS_EN
   output logic [31:0]       SymCount,
   output logic [31:0]       WordCount,
`endif
   output logic              Busy
);

   localparam int unsigned HDR_W  = $clog2(DATA_W + 1);
   localparam int unsigned CODE_W = HDR_W + DATA_W;
   localparam int unsigned FILL_W = $clog2(BUF_W + 1);
   localparam int unsigned PAD_W  = BUF_W - CODE_W;

   // The worst-case append happens at fill 31 with a full-length code.
   if (BUF_W < 31 + CODE_W) begin : g_buf_w_check
      $error("dpcm_packer: BUF_W too small for worst-case append");
   end
   if (DATA_W != 32) begin : g_data_w_check
      $error("dpcm_packer: only DATA_W = 32 is supported");
   end

   typedef enum logic [1:0] {
      StAccept = 2'd0,
      StDrain  = 2'd1,
      StFlush  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [BUF_W-1:0]    buf_q, buf_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic                pend_q, pend_d;
   logic                valid_q, last_q;
   logic [DATA_W-1:0]   data_q;

   logic                accept;
   logic [HDR_W-1:0]    len;
   logic [HDR_W-1:0]    shamt;
   logic [DATA_W-1:0]   aligned;
   logic [CODE_W-1:0]   code;
   logic [BUF_W-1:0]    placed;
   logic [FILL_W-1:0]   app_fill;

   assign ReadyIn  = (state_q == StAccept);
   assign accept   = ValidIn & ReadyIn;
   assign Busy     = (fill_q != '0) | pend_q;
   assign ValidOut = valid_q;
   assign DataOut  = data_q;
   assign Last     = last_q;

   // Significant length: position of the highest set bit plus one.
   always_comb begin
      len = '0;
      for (int i = 0; i < int'(DATA_W); i++) begin
         if (DataIn[i]) len = HDR_W'(i + 1);
      end
   end

   // Left-align the significant bits behind the header; L = 0 leaves the
   // payload empty because the shift pushes every bit out.
   always_comb begin
      shamt    = HDR_W'(DATA_W) - len;
      aligned  = DataIn << shamt;
      code     = {len, aligned};
      placed   = {code, {PAD_W{1'b0}}} >> fill_q;
      app_fill = fill_q + FILL_W'(HDR_W) + FILL_W'(len);
   end

   // Next buffer/fill/flush-pending values.
   always_comb begin
      buf_d  = buf_q;
      fill_d = fill_q;
      // A Flush while one is already pending folds into the same request.
      pend_d = pend_q | Flush;
      unique case (state_q)
         StAccept: begin
            if (accept) begin
               buf_d  = buf_q | placed;
               fill_d = app_fill;
            end
         end
         StDrain: begin
            // ValidOut is always high in this state, so ReadyOut completes it.
            if (ReadyOut) begin
               buf_d  = buf_q << DATA_W;
               fill_d = fill_q - FILL_W'(DATA_W);
            end
         end
         StFlush: begin
            if (fill_q == '0) begin
               pend_d = 1'b0;
            end else if (ReadyOut) begin
               buf_d  = '0;
               fill_d = '0;
               pend_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      if (fill_d >= FILL_W'(DATA_W)) begin
         state_d = StDrain;
      end else if (pend_d) begin
         state_d = StFlush;
      end else begin
         state_d = StAccept;
      end
   end

   // Output flops are loaded from the next state so that they always describe
   // the state currently held, with no combinational path from the inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StAccept;
         buf_q   <= '0;
         fill_q  <= '0;
         pend_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         fill_q  <= fill_d;
         pend_q  <= pend_d;
         data_q  <= buf_d[BUF_W-1 -: DATA_W];
         unique case (state_d)
            StDrain: begin
               valid_q <= 1'b1;
               last_q  <= 1'b0;
            end
            StFlush: begin
               // An empty buffer at flush time produces no word at all.
               valid_q <= (fill_d != '0);
               last_q  <= (fill_d != '0);
            end
            default: begin
               valid_q <= 1'b0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef DPCM_PACKER_STATS_EN
   logic [31:0] sym_q, word_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sym_q  <= '0;
         word_q <= '0;
      end else begin
         if (accept) sym_q <= sym_q + 32'd1;
         if (valid_q && ReadyOut) word_q <= word_q + 32'd1;
      end
   end

   assign SymCount  = sym_q;
   assign WordCount = word_q;
`endif

endmodule

// File: tb/tb_dpcm_packer.sv
// Testbench for dpcm_packer: table of single-residual + flush vectors plus
// hand-written sequences for drain, backpressure, empty flush and reset.

module tb_dpcm_packer;

   logic        clk;
   logic        rst_n;
   logic        ValidIn;
   logic [31:0] DataIn;
   logic        ReadyIn;
   logic        Flush;
   logic        ValidOut;
   logic [31:0] DataOut;
   logic        Last;
   logic        ReadyOut;
   logic        Busy;
`ifdef DPCM_PACKER_STATS_EN
   logic [31:0] SymCount;
   logic [31:0] WordCount;
`endif

   dpcm_packer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ValidIn   (ValidIn),
      .DataIn    (DataIn),
      .ReadyIn   (ReadyIn),
      .Flush     (Flush),
      .ValidOut  (ValidOut),
      .DataOut   (DataOut),
      .Last      (Last),
      .ReadyOut  (ReadyOut),
`ifdef DPCM_PACKER_STATS_EN
      .SymCount  (SymCount),
      .WordCount (WordCount),
`endif
      .Busy      (Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] din;
      logic [31:0] w0;
      logic        l0;
      logic        two;
      logic [31:0] w1;
   } vec_t;

   vec_t vecs [8];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Waits (bounded) for ValidOut, checks the word, and lets it hand off
   // (ReadyOut must be high).
   task automatic expect_word(input string name, input logic [31:0] w, input logic l);
      int k = 0;
      while (!ValidOut && k < 10) begin
         tick();
         k++;
      end
      check({name, "_valid"}, {31'd0, ValidOut}, 32'd1);
      if (ValidOut) begin
         check({name, "_data"}, DataOut, w);
         check({name, "_last"}, {31'd0, Last}, {31'd0, l});
      end
      tick();
   endtask

   // One residual accepted together with Flush, then the expected words.
   task automatic run_vec(input int i);
      int k = 0;
      string nm;
      nm = $sformatf("vec%0d", i);
      while (!ReadyIn && k < 10) begin
         tick();
         k++;
      end
      check({nm, "_ready"}, {31'd0, ReadyIn}, 32'd1);
      ValidIn = 1'b1;
      DataIn  = vecs[i].din;
      Flush   = 1'b1;
      tick();
      ValidIn = 1'b0;
      Flush   = 1'b0;
      expect_word({nm, "_w0"}, vecs[i].w0, vecs[i].l0);
      if (vecs[i].two) expect_word({nm, "_w1"}, vecs[i].w1, 1'b1);
      check({nm, "_busy_end"}, {31'd0, Busy}, 32'd0);
      check({nm, "_ready_end"}, {31'd0, ReadyIn}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h0000_0005, 32'h0E80_0000, 1'b1, 1'b0, 32'h0};
      vecs[1] = '{32'hFFFF_FFFF, 32'h83FF_FFFF, 1'b0, 1'b1, 32'hFC00_0000};
      vecs[2] = '{32'h0000_0001, 32'h0600_0000, 1'b1, 1'b0, 32'h0};
      vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0};
      vecs[4] = '{32'h8000_0000, 32'h8200_0000, 1'b0, 1'b1, 32'h0000_0000};
      vecs[5] = '{32'h0000_0010, 32'h1600_0000, 1'b1, 1'b0, 32'h0};
      vecs[6] = '{32'h0000_1234, 32'h3646_8000, 1'b1, 1'b0, 32'h0};
      vecs[7] = '{32'h0000_0003, 32'h0B00_0000, 1'b1, 1'b0, 32'h0};

      rst_n    = 1'b0;
      ValidIn  = 1'b0;
      DataIn   = '0;
      Flush    = 1'b0;
      ReadyOut = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      check("rst_valid", {31'd0, ValidOut}, 32'd0);
      check("rst_data", DataOut, 32'd0);
      check("rst_last", {31'd0, Last}, 32'd0);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check("rst_ready", {31'd0, ReadyIn}, 32'd1);

      for (int i = 0; i < 7; i++) run_vec(i);

      // Six zero residuals (36 bits) back-to-back, then Flush during the drain.
      for (int k = 0; k < 6; k++) begin
         check($sformatf("zeros_ready%0d", k), {31'd0, ReadyIn}, 32'd1);
         ValidIn = 1'b1;
         DataIn  = 32'h0;
         tick();
      end
      ValidIn = 1'b0;
      check("zeros_drain_ready", {31'd0, ReadyIn}, 32'd0);
      check("zeros_w0_valid", {31'd0, ValidOut}, 32'd1);
      check("zeros_w0_data", DataOut, 32'h0);
      check("zeros_w0_last", {31'd0, Last}, 32'd0);
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      expect_word("zeros_w1", 32'h0, 1'b1);
      check("zeros_ready_end", {31'd0, ReadyIn}, 32'd1);
      check("zeros_busy_end", {31'd0, Busy}, 32'd0);

      // Backpressure in DRAIN with another residual waiting on the input.
      ReadyOut = 1'b0;
      ValidIn  = 1'b1;
      DataIn   = 32'hFFFF_FFFF;
      tick();
      check("stall_ready_after_accept", {31'd0, ReadyIn}, 32'd0);
      check("stall_latency_valid", {31'd0, ValidOut}, 32'd1);
      for (int k = 0; k < 10; k++) begin
         tick();
         check($sformatf("stall%0d_data", k), DataOut, 32'h83FF_FFFF);
         check($sformatf("stall%0d_valid", k), {31'd0, ValidOut}, 32'd1);
         check($sformatf("stall%0d_ready", k), {31'd0, ReadyIn}, 32'd0);
      end
      ValidIn  = 1'b0;
      ReadyOut = 1'b1;
      expect_word("stall_w0", 32'h83FF_FFFF, 1'b0);
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      expect_word("stall_w1", 32'hFC00_0000, 1'b1);
      check("stall_busy_end", {31'd0, Busy}, 32'd0);

      // Flush with nothing buffered: no word, ready again within two cycles.
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      check("eflush_valid0", {31'd0, ValidOut}, 32'd0);
      check("eflush_busy0", {31'd0, Busy}, 32'd1);
      tick();
      check("eflush_valid1", {31'd0, ValidOut}, 32'd0);
      check("eflush_last1", {31'd0, Last}, 32'd0);
      check("eflush_ready1", {31'd0, ReadyIn}, 32'd1);
      check("eflush_busy1", {31'd0, Busy}, 32'd0);

      // Asynchronous reset in the middle of a drain.
      ReadyOut = 1'b0;
      ValidIn  = 1'b1;
      DataIn   = 32'hFFFF_FFFF;
      tick();
      ValidIn = 1'b0;
      check("arst_pre_valid", {31'd0, ValidOut}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, ValidOut}, 32'd0);
      check("arst_last", {31'd0, Last}, 32'd0);
      check("arst_busy", {31'd0, Busy}, 32'd0);
      tick();
      rst_n    = 1'b1;
      ReadyOut = 1'b1;
      tick();
      run_vec(7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
